// File: rtl/sha256_round_core.sv
// Iterative SHA-256 compression core: 64 rounds per 512-bit block, one schedule
// word per round over valid/ready, result folded into the incoming chaining value.

module func_sigma0 (
  input  logic [31:0] x_i,
  output logic [31:0] y_c
);
  assign y_c = {x_i[1:0], x_i[31:2]} ^ {x_i[12:0], x_i[31:13]} ^ {x_i[21:0], x_i[31:22]};
endmodule

module func_sigma1 (
  input  logic [31:0] x_i,
  output logic [31:0] y_c
);
  assign y_c = {x_i[5:0], x_i[31:6]} ^ {x_i[10:0], x_i[31:11]} ^ {x_i[24:0], x_i[31:25]};
endmodule

module sha256_round_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] H_in,
  input  logic         w_valid,
  input  logic [31:0]  w_data,
  output logic         w_ready,
  output logic         busy,
  output logic         done,
  output logic [255:0] H_out
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NWORDS = 8;
  localparam int unsigned T_W    = 6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;

  logic [1:0]                           state_q, state_d;
  logic [T_W-1:0]                       t_q, t_d;
  logic [NWORDS-1:0][WORD_W-1:0]        wv_q, wv_d;    // [7]=a ... [0]=h
  logic [NWORDS-1:0][WORD_W-1:0]        hold_q, hold_d;
  logic [NWORDS-1:0][WORD_W-1:0]        hout_q, hout_d;
  logic                                 done_q, done_d;
  logic                                 busy_q, busy_d;
  logic                                 wready_q, wready_d;

  logic [WORD_W-1:0] sig0_c, sig1_c, ch_c, maj_c, t1_c, t2_c;

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; 6'd63: k = 32'hc67178f2;
      default: k = 32'h0;
    endcase
    return k;
  endfunction

  func_sigma0 u_sigma0 (.x_i(wv_q[7]), .y_c(sig0_c));
  func_sigma1 u_sigma1 (.x_i(wv_q[3]), .y_c(sig1_c));

  // Round datapath on the current working variables
  always_comb begin
    ch_c  = (wv_q[3] & wv_q[2]) ^ (~wv_q[3] & wv_q[1]);
    maj_c = (wv_q[7] & wv_q[6]) ^ (wv_q[7] & wv_q[5]) ^ (wv_q[6] & wv_q[5]);
    t1_c  = wv_q[0] + sig1_c + ch_c + k_rom(t_q) + w_data;
    t2_c  = sig0_c + maj_c;
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    wv_d    = wv_q;
    hold_d  = hold_q;
    hout_d  = hout_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          hold_d  = H_in;
          wv_d    = H_in;
          t_d     = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        if (w_valid) begin
          wv_d = {t1_c + t2_c, wv_q[7], wv_q[6], wv_q[5],
                  wv_q[4] + t1_c, wv_q[3], wv_q[2], wv_q[1]};
          t_d  = T_W'(t_q + T_W'(1));
          if (t_q == T_W'(63)) state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        for (int i = 0; i < NWORDS; i++) hout_d[i] = hold_q[i] + wv_q[i];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d != S_IDLE);
    wready_d = (state_d == S_ROUND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      wv_q     <= '0;
      hold_q   <= '0;
      hout_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      wready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      wv_q     <= wv_d;
      hold_q   <= hold_d;
      hout_q   <= hout_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      wready_q <= wready_d;
    end
  end

  assign w_ready = wready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign H_out   = hout_q;

endmodule

// File: tb/tb_sha256_round_core.sv
// Scoreboard bench for sha256_round_core: known digests, stalls, back-to-back,
// resets, ignored start and modular wrap.
module tb_sha256_round_core;

  logic         clk = 1'b0;
  logic         rst, start, w_valid;
  logic [255:0] H_in;
  logic [31:0]  w_data;
  logic         w_ready, busy, done;
  logic [255:0] H_out;

  always #5 clk = ~clk;

  sha256_round_core dut (
    .clk(clk), .rst(rst), .start(start), .H_in(H_in), .w_valid(w_valid),
    .w_data(w_data), .w_ready(w_ready), .busy(busy), .done(done), .H_out(H_out)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [255:0] exp_q[$];
  logic [31:0]  blk[16];
  logic [31:0]  wsched[64];

  localparam logic [255:0] IV  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KT[64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic expand();
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) wsched[t] = blk[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(wsched[t-15], 7) ^ rotr(wsched[t-15], 18) ^ (wsched[t-15] >> 3);
      s1 = rotr(wsched[t-2], 17) ^ rotr(wsched[t-2], 19) ^ (wsched[t-2] >> 10);
      wsched[t] = s1 + wsched[t-7] + s0 + wsched[t-16];
    end
  endtask

  function automatic logic [255:0] model(input logic [255:0] hin);
    logic [31:0] v[8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
           + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wsched[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
           + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    expand();
  endtask

  // Starts a block now (caller is 1 time unit after an edge) and feeds wsched.
  task automatic run_block(input logic [255:0] hin, input int stall_pct, input int pulse_at,
                           input int abort_at, output int lat, output int stalls,
                           output int words, output bit to);
    start = 1'b1; H_in = hin; w_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    H_in  = {8{32'($urandom())}};
    lat = 1; stalls = 0; words = 0; to = 1'b0;
    while (!(abort_at >= 0 && words == abort_at)) begin
      start   = (lat == pulse_at);
      w_data  = (words < 64) ? wsched[words] : 32'($urandom());
      w_valid = (words < 64) && ($urandom_range(99) >= stall_pct);
      if (w_ready && !w_valid) stalls++;
      if (w_ready && w_valid) words++;
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (lat > 2000) begin to = 1'b1; break; end
    end
    start = 1'b0; w_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      start = 1'($urandom()); w_valid = 1'($urandom());
      H_in = {8{32'($urandom())}}; w_data = 32'($urandom());
      @(posedge clk); #1;
    end
    n_vec++;
    if ({H_out, done, busy, w_ready} !== 259'h0) begin
      n_err++;
      $display("FAIL reset_outputs: H_out=%h done=%b busy=%b w_ready=%b, required all 0", H_out, done, busy, w_ready);
    end
    start = 1'b1; w_valid = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_start_busy: busy=%b required 0", busy); end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({busy, w_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_start_after: busy=%b w_ready=%b required 0 0", busy, w_ready);
    end
  endtask

  task automatic test_abc();
    int lat, st, wd; bit to;
    logic [255:0] e, prev;
    load_abc();
    exp_q.push_back(ABC);
    run_block(IV, 0, -1, -1, lat, st, wd, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || lat != 66) begin n_err++; $display("FAIL abc_latency: got %0d (timeout=%0b), required 66", lat, to); end
    n_vec++;
    if (H_out !== e) begin n_err++; $display("FAIL abc_digest: got %h required %h", H_out, e); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL abc_busy_with_done: busy=%b required 0", busy); end
    prev = H_out;
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0 || H_out !== e) begin
      n_err++; $display("FAIL abc_done_pulse_hold: done=%b H_out=%h required 0 %h", done, H_out, prev);
    end
  endtask

  task automatic test_stalls();
    int lat, st, wd; bit to;
    logic [255:0] e;
    load_abc();
    exp_q.push_back(ABC);
    run_block(IV, 30, -1, -1, lat, st, wd, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || lat != 66 + st) begin
      n_err++; $display("FAIL stall_latency: got %0d required %0d (stalls %0d)", lat, 66 + st, st);
    end
    n_vec++;
    if (H_out !== e) begin n_err++; $display("FAIL stall_digest: got %h required %h", H_out, e); end
  endtask

  task automatic test_back_to_back();
    int lat, st, wd; bit to;
    logic [255:0] e;
    blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
            32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    expand();
    exp_q.push_back(model(IV));
    run_block(IV, 0, -1, -1, lat, st, wd, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || H_out !== e) begin n_err++; $display("FAIL b2b_block1: got %h required %h", H_out, e); end
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[15] = 32'h000001c0;
    expand();
    exp_q.push_back(TWO);
    run_block(H_out, 0, -1, -1, lat, st, wd, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || lat != 66) begin n_err++; $display("FAIL b2b_latency: got %0d required 66", lat); end
    n_vec++;
    if (H_out !== e) begin n_err++; $display("FAIL b2b_digest: got %h required %h", H_out, e); end
  endtask

  task automatic test_reset_mid();
    int lat, st, wd; bit to;
    logic [255:0] e;
    load_abc();
    run_block(IV, 0, -1, 20, lat, st, wd, to);
    n_vec++;
    if (wd != 20 || busy !== 1'b1) begin
      n_err++; $display("FAIL mid_pre_reset: words=%0d busy=%b required 20 1", wd, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_vec++;
    if ({H_out, done, busy, w_ready} !== 259'h0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: H_out=%h done=%b busy=%b w_ready=%b, required all 0", H_out, done, busy, w_ready);
    end
    exp_q.push_back(ABC);
    run_block(IV, 0, -1, -1, lat, st, wd, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || lat != 66 || H_out !== e) begin
      n_err++; $display("FAIL mid_rerun: lat=%0d H_out=%h required 66 %h", lat, H_out, e);
    end
  endtask

  task automatic test_ignored_start();
    int lat, st, wd; bit to;
    logic [255:0] e;
    load_abc();
    exp_q.push_back(ABC);
    run_block(IV, 0, 30, -1, lat, st, wd, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || lat != 66 || wd != 64) begin
      n_err++; $display("FAIL ign_start_count: lat=%0d words=%0d required 66 64", lat, wd);
    end
    n_vec++;
    if (H_out !== e) begin n_err++; $display("FAIL ign_start_digest: got %h required %h", H_out, e); end
  endtask

  task automatic test_wrap();
    int lat, st, wd; bit to;
    logic [255:0] e;
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    expand();
    exp_q.push_back(model({8{32'hffffffff}}));
    run_block({8{32'hffffffff}}, 0, -1, -1, lat, st, wd, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || H_out !== e) begin n_err++; $display("FAIL wrap_digest: got %h required %h", H_out, e); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; w_valid = 1'b0; H_in = '0; w_data = '0;
    @(posedge clk); #1;
    test_reset();
    test_abc();
    test_stalls();
    test_back_to_back();
    test_reset_mid();
    test_ignored_start();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
